dpu_job_scheduler: RTL and testbench
====================================

DPU_JOB_SCHEDULER -- requirements
Module: dpu_job_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, equal to the shared data process unit's WIDTH.
REQ-002 SHALL have parameter DEPTH, default 4: operand pairs per job, equal to the shared data process unit's DEPTH.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters, minimum 2.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before a job is aborted.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port req, input, NREQ bits: per-requester job request, level.
REQ-008 SHALL have port req_a, input, NREQ*DEPTH*WIDTH bits: requester i, operand k at bits [(i*DEPTH+k)*WIDTH +: WIDTH].
REQ-009 SHALL have port req_b, input, NREQ*DEPTH*WIDTH bits: second operand vector, same packing as req_a.
REQ-010 SHALL have port req_ack, output, NREQ bits: one-hot pulse; the job is accepted and operands are captured.
REQ-011 SHALL have port dpu_en, output, 1 bit: start pulse to the data process unit.
REQ-012 SHALL have port dpu_a, output, WIDTH bits: data process unit operand stream 1.
REQ-013 SHALL have port dpu_b, output, WIDTH bits: data process unit operand stream 2.
REQ-014 SHALL have port dpu_valid, input, 1 bit: data process unit result valid.
REQ-015 SHALL have port dpu_data, input, 2*WIDTH*DEPTH bits: data process unit parallel result.
REQ-016 SHALL have port resp_valid, output, 1 bit: response available.
REQ-017 SHALL have port resp_ready, input, 1 bit: response consumer ready.
REQ-018 SHALL have port resp_id, output, clog2(NREQ) bits: index of the requester that owns the response.
REQ-019 SHALL have port resp_data, output, 2*WIDTH*DEPTH bits: captured result.
REQ-020 SHALL have port resp_err, output, 1 bit: the job timed out.
REQ-021 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-022 SHALL have port job_cnt, output, 16 bits: completed jobs, wraps modulo 2^16.
REQ-023 SHALL have port tmo_cnt, output, 8 bits: timed-out jobs, saturates at 255.

Function
REQ-024 SHALL implement an FSM with states IDLE, ISSUE, LOAD, WAIT and RESP; all outputs are registered or decoded from state only.
REQ-025 IDLE: when req is nonzero, SHALL select a winner round-robin, capture its DEPTH operand pairs, latch resp_id, and go to ISSUE; otherwise SHALL remain in IDLE.
REQ-026 Round-robin: search SHALL start at (last_grant+1) mod NREQ; last_grant updates only on a grant.
REQ-027 ISSUE: SHALL last exactly 1 cycle, with dpu_en=1 and req_ack[winner]=1; SHALL then go to LOAD with the operand counter set to 0.
REQ-028 LOAD: SHALL last exactly DEPTH cycles; in cycle k, dpu_a SHALL equal operand a[k] and dpu_b SHALL equal operand b[k]; after cycle DEPTH-1 SHALL go to WAIT.
REQ-029 Outside LOAD, dpu_a and dpu_b SHALL be 0; outside ISSUE, dpu_en and req_ack SHALL be 0.
REQ-030 WAIT: SHALL clear the watchdog on entry and increment it every cycle.
REQ-031 WAIT, on dpu_valid=1: SHALL set resp_data=dpu_data and resp_err=0, and go to RESP.
REQ-032 WAIT, when the watchdog reaches TIMEOUT-1 without dpu_valid: SHALL set resp_data=0 and resp_err=1, increment tmo_cnt, and go to RESP.
REQ-033 dpu_valid and watchdog expiry in the same cycle: dpu_valid SHALL take precedence.
REQ-034 dpu_valid outside WAIT SHALL be ignored.
REQ-035 RESP: resp_valid SHALL be 1, with resp_id, resp_data and resp_err held stable.
REQ-036 RESP, when resp_valid and resp_ready are both 1: SHALL increment job_cnt (including timed-out jobs) and go to IDLE.
REQ-037 Only one job SHALL be outstanding; no req_ack while busy=1.
REQ-038 Requester obligation: hold req and its operands stable until req_ack; a deasserted req is never granted.
REQ-039 Latency: from the req sample in IDLE to the first dpu_valid-eligible WAIT cycle SHALL be 1+DEPTH+1 cycles.

Reset
REQ-040 While rstn=0, SHALL hold: state=IDLE, all outputs 0, last_grant=NREQ-1 (requester 0 has first priority), counters, watchdog and operand registers 0.
REQ-041 Reset asserted mid-job SHALL abort the job with no response; after release, the first grant SHALL follow REQ-040 priority.

Verification (WIDTH=8, DEPTH=4, NREQ=4, TIMEOUT=64; data process unit model returns a fixed value)
REQ-042 req=0001, a={1,2,3,4}, b={5,6,7,8}, model returns 0x...1234 -> req_ack=0001 with dpu_en in the same cycle; dpu_a=1,2,3,4 and dpu_b=5,6,7,8 on the next 4 cycles; resp_id=0, resp_data=0x...1234, resp_err=0, job_cnt=1.
REQ-043 req=1111 held, resp_ready=1 -> grant order 0,1,2,3,0.
REQ-044 Model never asserts dpu_valid -> RESP entered 64 cycles after WAIT entry, resp_err=1, resp_data=0, tmo_cnt=1.
REQ-045 resp_ready=0 for 10 cycles in RESP -> resp_valid and all resp fields stable, req_ack stays 0; completion on the cycle resp_ready=1.
REQ-046 rstn pulsed low during LOAD cycle 2 -> all outputs 0 immediately; with req=1010 after release, requester 1 is granted first.
REQ-047 Preload job_cnt=16'hFFFF and complete one job -> job_cnt=0.

Source files
------------

// File: rtl/dpu_job_scheduler.sv
// dpu_job_scheduler: round-robin front end that feeds one shared data process unit.
// Ports: req/req_a/req_b in, req_ack out; dpu_* stream; resp_* valid/ready; busy, job_cnt, tmo_cnt.
module dpu_job_scheduler #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW = $clog2(NREQ),
  localparam int OW  = NREQ * DEPTH * WIDTH,
  localparam int DW  = 2 * WIDTH * DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [OW-1:0]     req_a,
  input  logic [OW-1:0]     req_b,
  output logic [NREQ-1:0]   req_ack,
  output logic              dpu_en,
  output logic [WIDTH-1:0]  dpu_a,
  output logic [WIDTH-1:0]  dpu_b,
  input  logic              dpu_valid,
  input  logic [DW-1:0]     dpu_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [DW-1:0]     resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [15:0]       job_cnt,
  output logic [7:0]        tmo_cnt
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   win;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    wd;
  logic [WIDTH-1:0] opa [DEPTH];
  logic [WIDTH-1:0] opb [DEPTH];

  // First requesting index after last_grant, wrapping.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    win   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_grant) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NREQ - 1);
      req_ack    <= '0;
      dpu_en     <= 1'b0;
      dpu_a      <= '0;
      dpu_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      job_cnt    <= '0;
      tmo_cnt    <= '0;
      cnt        <= '0;
      wd         <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        opa[k] <= '0;
        opb[k] <= '0;
      end
    end else begin
      req_ack <= '0;
      dpu_en  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            state      <= S_ISSUE;
            busy       <= 1'b1;
            req_ack    <= NREQ'(1) << win;
            dpu_en     <= 1'b1;
            resp_id    <= win;
            last_grant <= win;
            for (int k = 0; k < DEPTH; k++) begin
              opa[k] <= req_a[(int'(win) * DEPTH + k) * WIDTH +: WIDTH];
              opb[k] <= req_b[(int'(win) * DEPTH + k) * WIDTH +: WIDTH];
            end
          end
        end
        S_ISSUE: begin
          state <= S_LOAD;
          cnt   <= '0;
          dpu_a <= opa[0];
          dpu_b <= opb[0];
        end
        // dpu_a/b are registered one cycle ahead of the LOAD slot.
        S_LOAD: begin
          if (cnt == CW'(DEPTH - 1)) begin
            state <= S_WAIT;
            wd    <= '0;
            dpu_a <= '0;
            dpu_b <= '0;
          end else begin
            cnt   <= cnt + CW'(1);
            dpu_a <= opa[cnt + CW'(1)];
            dpu_b <= opb[cnt + CW'(1)];
          end
        end
        // A result arriving on the expiry cycle still wins.
        S_WAIT: begin
          if (dpu_valid) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_data  <= dpu_data;
            resp_err   <= 1'b0;
          end else if (wd == TW'(TIMEOUT - 1)) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            if (tmo_cnt != 8'hFF) begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end else begin
            wd <= wd + TW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            job_cnt    <= job_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpu_job_scheduler.sv
// tb_dpu_job_scheduler: directed + randomized checks of dpu_job_scheduler
// against a reference model of grant order, operand stream and responses.
module tb_dpu_job_scheduler;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = $clog2(NREQ);
  localparam int OW      = NREQ * DEPTH * WIDTH;
  localparam int DW      = 2 * WIDTH * DEPTH;

  logic             clk;
  logic             rstn;
  logic [NREQ-1:0]  req;
  logic [OW-1:0]    req_a;
  logic [OW-1:0]    req_b;
  logic [NREQ-1:0]  req_ack;
  logic             dpu_en;
  logic [WIDTH-1:0] dpu_a;
  logic [WIDTH-1:0] dpu_b;
  logic             dpu_valid;
  logic [DW-1:0]    dpu_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [DW-1:0]    resp_data;
  logic             resp_err;
  logic             busy;
  logic [15:0]      job_cnt;
  logic [7:0]       tmo_cnt;

  dpu_job_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .dpu_en(dpu_en), .dpu_a(dpu_a), .dpu_b(dpu_b),
    .dpu_valid(dpu_valid), .dpu_data(dpu_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .job_cnt(job_cnt), .tmo_cnt(tmo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp;
  int nfail;
  int mlast;
  int mjobs;
  int mtmo;
  logic [OW-1:0] va;
  logic [OW-1:0] vb;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 64'(req_ack), 0);
    chk({tag, "_en"}, 64'(dpu_en), 0);
    chk({tag, "_a"}, 64'(dpu_a), 0);
    chk({tag, "_b"}, 64'(dpu_b), 0);
    chk({tag, "_rv"}, 64'(resp_valid), 0);
    chk({tag, "_id"}, 64'(resp_id), 0);
    chk({tag, "_rd"}, 64'(resp_data), 0);
    chk({tag, "_re"}, 64'(resp_err), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_jc"}, 64'(job_cnt), 0);
    chk({tag, "_tc"}, 64'(tmo_cnt), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req = '0;
    dpu_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rstn = 1'b1;
    mlast = NREQ - 1;
    mjobs = 0;
    mtmo = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < OW; i++) begin
      va[i] = 1'($urandom_range(0, 1));
      vb[i] = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(mlast + i) % NREQ]) return (mlast + i) % NREQ;
    end
    return -1;
  endfunction

  // vd: WAIT cycle carrying dpu_valid (negative = never).
  task automatic run_job(input logic [NREQ-1:0] r, input bit keep,
                         input int vd, input int hold,
                         input logic [DW-1:0] rdata, input bit spur);
    int w;
    int n;
    bit eerr;
    logic [DW-1:0] er;
    w = pick(r);
    mlast = w;
    eerr = (vd < 0) || (vd >= TIMEOUT);
    n = eerr ? TIMEOUT : vd + 1;
    er = eerr ? '0 : rdata;
    req = r;
    req_a = va;
    req_b = vb;
    @(posedge clk);
    #1;
    chk("ack", 64'(req_ack), 64'(1) << w);
    chk("en", 64'(dpu_en), 1);
    chk("busy", 64'(busy), 1);
    if (!keep) req = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dpu_valid = spur;
      dpu_data = ~rdata;
      @(posedge clk);
      #1;
      chk("load_a", 64'(dpu_a), 64'(va[(w * DEPTH + k) * WIDTH +: WIDTH]));
      chk("load_b", 64'(dpu_b), 64'(vb[(w * DEPTH + k) * WIDTH +: WIDTH]));
      chk("load_ack", 64'(req_ack), 0);
      chk("load_en", 64'(dpu_en), 0);
    end
    dpu_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_a", 64'(dpu_a), 0);
    for (int c = 0; c < n; c++) begin
      if (c == vd) begin
        dpu_valid = 1'b1;
        dpu_data = rdata;
      end
      chk("wait_rv", 64'(resp_valid), 0);
      @(posedge clk);
      #1;
      dpu_valid = 1'b0;
    end
    if (eerr && mtmo < 255) mtmo++;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_rv", 64'(resp_valid), 1);
      chk("resp_id", 64'(resp_id), 64'(w));
      chk("resp_data", 64'(resp_data), 64'(er));
      chk("resp_err", 64'(resp_err), 64'(eerr));
      chk("resp_ack", 64'(req_ack), 0);
      chk("tmo_cnt", 64'(tmo_cnt), 64'(mtmo));
      if (h < hold) begin
        @(posedge clk);
        #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    mjobs = (mjobs + 1) % 65536;
    chk("done_rv", 64'(resp_valid), 0);
    chk("done_busy", 64'(busy), 0);
    chk("job_cnt", 64'(job_cnt), 64'(mjobs));
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    req_a = '0;
    req_b = '0;
    dpu_data = '0;
    do_reset();

    va = '0;
    vb = '0;
    for (int k = 0; k < DEPTH; k++) begin
      va[k * WIDTH +: WIDTH] = WIDTH'(k + 1);
      vb[k * WIDTH +: WIDTH] = WIDTH'(k + 5);
    end
    run_job(4'b0001, 1'b0, 2, 0, 64'h1234, 1'b0);

    do_reset();
    for (int j = 0; j < 5; j++) begin
      rand_ops();
      run_job(4'b1111, 1'b1, 1, 0, {$urandom, $urandom}, 1'b1);
    end
    req = '0;

    rand_ops();
    run_job(4'b0100, 1'b0, -1, 0, {$urandom, $urandom}, 1'b0);
    rand_ops();
    run_job(4'b0010, 1'b0, TIMEOUT - 1, 0, {$urandom, $urandom}, 1'b0);
    rand_ops();
    run_job(4'b1000, 1'b0, 0, 10, {$urandom, $urandom}, 1'b0);

    for (int j = 0; j < 20; j++) begin
      rand_ops();
      run_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b0,
              $urandom_range(0, 6), $urandom_range(0, 3),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    for (int j = 0; j < 256; j++) begin
      rand_ops();
      run_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b0,
              -1, 0, {$urandom, $urandom}, 1'b0);
    end
    chk("tmo_sat", 64'(tmo_cnt), 255);

    rand_ops();
    req = 4'b0001;
    req_a = va;
    req_b = vb;
    @(posedge clk);
    #1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_a", 64'(dpu_a), 64'(va[2 * WIDTH +: WIDTH]));
    rstn = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    mlast = NREQ - 1;
    mjobs = 0;
    mtmo = 0;
    rand_ops();
    run_job(4'b1010, 1'b0, 3, 0, {$urandom, $urandom}, 1'b0);

    force dut.job_cnt = 16'hFFFF;
    #1;
    release dut.job_cnt;
    #1;
    mjobs = 16'hFFFF;
    chk("preload", 64'(job_cnt), 64'(mjobs));
    rand_ops();
    run_job(4'b0001, 1'b0, 1, 0, {$urandom, $urandom}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
